// File: rtl/responder_ctrl.sv
// Quiz-round controller: captures settings, arbitrates buzz-ins, runs the
// answer countdown and keeps per-user scores.
// Optional feature: define FALSE_START_EN to penalise buzzes pressed in READY.
module responder_ctrl #(
  parameter int unsigned NUSER   = 8,
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               endset,
  input  logic [7:0]         maxtime,
  input  logic [3:0]         maxuser,
  input  logic [3:0]         scorejia,
  input  logic [3:0]         scorejian,
  input  logic               start,
  input  logic [NUSER-1:0]   buzz,
  input  logic               judge_ok,
  input  logic               judge_bad,
  input  logic               tick,
  input  logic [3:0]         rd_idx,
  output logic [2:0]         state,
  output logic [3:0]         winner,
  output logic               winner_valid,
  output logic [7:0]         timeleft,
  output logic               timeout,
  output logic [SCORE_W-1:0] rd_score
);

  localparam int unsigned SW1 = SCORE_W + 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReady  = 3'd1,
    StOpen   = 3'd2,
    StAnswer = 3'd3
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         winner_q, winner_d;
  logic               wvalid_q, wvalid_d;
  logic [7:0]         timeleft_q, timeleft_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         maxtime_q, maxtime_d;
  logic [3:0]         nuser_q, nuser_d;
  logic [3:0]         jia_q, jia_d;
  logic [3:0]         jian_q, jian_d;
  logic [SCORE_W-1:0] score_q [NUSER];

  logic [NUSER-1:0]   user_mask;
  logic [4:0]         buzz_find;
  logic [3:0]         n_clamp;

  logic               pen_en, rew_en;
  logic [3:0]         upd_idx;
  logic [SCORE_W-1:0] cur_score, new_score;
  logic [SW1-1:0]     sum, diff;

  // Returns {hit, index} of the lowest set bit.
  function automatic logic [4:0] find_lowest(input logic [NUSER-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = int'(NUSER) - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

`ifdef FALSE_START_EN
  logic [NUSER-1:0] buzz_q;
  logic [4:0]       fs_find;
  assign fs_find = find_lowest(buzz & ~buzz_q & user_mask);
`endif

  // Users at or above the captured count are masked out; clamp new count to 1..NUSER.
  always_comb begin
    user_mask = '0;
    for (int i = 0; i < int'(NUSER); i++) user_mask[i] = (4'(i) < nuser_q);
    if (maxuser == 4'd0)             n_clamp = 4'd1;
    else if (maxuser > 4'(NUSER))    n_clamp = 4'(NUSER);
    else                             n_clamp = maxuser;
  end

  assign buzz_find = find_lowest(buzz & user_mask);

  // Next-state logic for round FSM, countdown and score update requests.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    wvalid_d   = wvalid_q;
    timeleft_d = timeleft_q;
    timeout_d  = 1'b0;
    maxtime_d  = maxtime_q;
    nuser_d    = nuser_q;
    jia_d      = jia_q;
    jian_d     = jian_q;
    pen_en     = 1'b0;
    rew_en     = 1'b0;
    upd_idx    = winner_q;

    if ((state_q == StIdle || state_q == StReady) && endset) begin
      maxtime_d = maxtime;
      nuser_d   = n_clamp;
      jia_d     = scorejia;
      jian_d    = scorejian;
    end

    case (state_q)
      StIdle: begin
        if (endset) state_d = StReady;
      end
      StReady: begin
        if (start) begin
          state_d    = StOpen;
          timeleft_d = maxtime_q;
        end
`ifdef FALSE_START_EN
        if (fs_find[4]) begin
          pen_en  = 1'b1;
          upd_idx = fs_find[3:0];
        end
`endif
      end
      StOpen: begin
        // A buzz beats an expiring tick on the same cycle.
        if (buzz_find[4]) begin
          state_d    = StAnswer;
          winner_d   = buzz_find[3:0];
          wvalid_d   = 1'b1;
          timeleft_d = maxtime_q;
        end else if (tick && timeleft_q == 8'd1) begin
          timeleft_d = 8'd0;
          timeout_d  = 1'b1;
          state_d    = StReady;
        end else if (tick && timeleft_q > 8'd1) begin
          timeleft_d = timeleft_q - 8'd1;
        end
      end
      StAnswer: begin
        if (tick && timeleft_q == 8'd1) begin
          timeleft_d = 8'd0;
          timeout_d  = 1'b1;
        end else if (tick && timeleft_q > 8'd1) begin
          timeleft_d = timeleft_q - 8'd1;
        end
        // Penalty (judge_bad or expiry) outranks reward.
        if (judge_bad || (tick && timeleft_q == 8'd1)) pen_en = 1'b1;
        else if (judge_ok)                               rew_en = 1'b1;
        if (pen_en || rew_en) begin
          state_d  = StReady;
          wvalid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating add / floored subtract on the selected user's score.
  always_comb begin
    cur_score = '0;
    for (int i = 0; i < int'(NUSER); i++) begin
      if (upd_idx == 4'(i)) cur_score = score_q[i];
    end
    sum  = {1'b0, cur_score} + SW1'(jia_q);
    diff = {1'b0, cur_score} - SW1'(jian_q);
    if (rew_en) new_score = sum[SCORE_W]  ? '1 : sum[SCORE_W-1:0];
    else        new_score = diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
  end

  // State, configuration and score registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      winner_q   <= '0;
      wvalid_q   <= 1'b0;
      timeleft_q <= '0;
      timeout_q  <= 1'b0;
      maxtime_q  <= '0;
      nuser_q    <= '0;
      jia_q      <= '0;
      jian_q     <= '0;
      for (int i = 0; i < int'(NUSER); i++) score_q[i] <= '0;
`ifdef FALSE_START_EN
      buzz_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      wvalid_q   <= wvalid_d;
      timeleft_q <= timeleft_d;
      timeout_q  <= timeout_d;
      maxtime_q  <= maxtime_d;
      nuser_q    <= nuser_d;
      jia_q      <= jia_d;
      jian_q     <= jian_d;
      for (int i = 0; i < int'(NUSER); i++) begin
        if ((pen_en || rew_en) && upd_idx == 4'(i)) score_q[i] <= new_score;
      end
`ifdef FALSE_START_EN
      buzz_q     <= buzz;
`endif
    end
  end

  // Combinational score read; out-of-range index reads as zero.
  always_comb begin
    rd_score = '0;
    for (int i = 0; i < int'(NUSER); i++) begin
      if (rd_idx == 4'(i)) rd_score = score_q[i];
    end
  end

  assign state        = state_q;
  assign winner       = winner_q;
  assign winner_valid = wvalid_q;
  assign timeleft     = timeleft_q;
  assign timeout      = timeout_q;

endmodule
